// File: rtl/gauss_acc_ctrl.sv
// 3x3 Gaussian (1-2-1/2-4-2/1-2-1) accumulator with valid/ready handshakes.
// One window is accumulated tap by tap through a shared HA/FA ripple adder.

module gauss_ha (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

module gauss_fa (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (ci & (a ^ b));
endmodule

module gauss_acc_ctrl #(
  parameter int DATA_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [9*DATA_W-1:0]   pix_win,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_pix,
  output logic                  busy,
  output logic [3:0]            tap_idx
);

  localparam int ACC_W = DATA_W + 4;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] ACC  = 2'd1;
  localparam logic [1:0] OUT  = 2'd2;

  logic [1:0]          state;
  logic [9*DATA_W-1:0] win;
  logic [ACC_W-1:0]    acc;

  logic [DATA_W-1:0]   tap;
  logic [1:0]          shift;
  logic [ACC_W-1:0]    addend;
  logic [ACC_W-1:0]    sum;
  logic [ACC_W-1:0]    carry;
  logic [ACC_W-1:0]    acc_nxt;
  logic [DATA_W-1:0]   rnd;
  logic [DATA_W-1:0]   rcarry;
  logic [DATA_W-1:0]   pix_nxt;

  always_comb begin
    tap = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      if (tap_idx == 4'(k)) tap = win[k*DATA_W +: DATA_W];
    end
  end

  always_comb begin
    shift = 2'd0;
    case (tap_idx)
      4'd1, 4'd3, 4'd5, 4'd7: shift = 2'd1;
      4'd4:                   shift = 2'd2;
      default:                shift = 2'd0;
    endcase
  end

  assign addend = {4'b0000, tap} << shift;

  gauss_ha u_add0 (.a(acc[0]), .b(addend[0]), .s(sum[0]), .c(carry[0]));

  for (genvar i = 1; i < ACC_W; i++) begin : g_add
    gauss_fa u_fa (
      .a (acc[i]),
      .b (addend[i]),
      .ci(carry[i-1]),
      .s (sum[i]),
      .co(carry[i])
    );
  end

  // Carry-out cannot occur for legal inputs; clamping keeps the chain fully consumed.
  assign acc_nxt = carry[ACC_W-1] ? '1 : sum;

  // Round half up: increment acc[ACC_W-1:4] by acc[3] through an HA chain.
  gauss_ha u_rnd0 (.a(acc_nxt[4]), .b(acc_nxt[3]), .s(rnd[0]), .c(rcarry[0]));

  for (genvar i = 1; i < DATA_W; i++) begin : g_rnd
    gauss_ha u_ha (
      .a(acc_nxt[4+i]),
      .b(rcarry[i-1]),
      .s(rnd[i]),
      .c(rcarry[i])
    );
  end

  assign pix_nxt = rcarry[DATA_W-1] ? '1 : rnd;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      win     <= '0;
      acc     <= '0;
      tap_idx <= '0;
      out_pix <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            win     <= pix_win;
            acc     <= '0;
            tap_idx <= '0;
            state   <= ACC;
          end
        end
        ACC: begin
          if (tap_idx > 4'd8) begin
            tap_idx <= '0;
            state   <= IDLE;
          end else begin
            acc <= acc_nxt;
            if (tap_idx == 4'd8) begin
              out_pix <= pix_nxt;
              tap_idx <= '0;
              state   <= OUT;
            end else begin
              tap_idx <= tap_idx + 4'd1;
            end
          end
        end
        OUT: begin
          if (out_ready) state <= IDLE;
        end
        default: begin
          tap_idx <= '0;
          state   <= IDLE;
        end
      endcase
    end
  end

  assign in_ready  = (state == IDLE);
  assign out_valid = (state == OUT);
  assign busy      = (state == ACC) || (state == OUT);

endmodule

// File: tb/tb_gauss_acc_ctrl.sv
// Directed bench for gauss_acc_ctrl: expected pixels are queued when a window
// is offered and popped when out_valid appears.

module tb_gauss_acc_ctrl;

  localparam int DW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [9*DW-1:0]   pix_win = '0;
  logic              out_valid;
  logic              out_ready = 1'b1;
  logic [DW-1:0]     out_pix;
  logic              busy;
  logic [3:0]        tap_idx;

  int checks = 0;
  int errors = 0;
  int unsigned exp_q[$];

  gauss_acc_ctrl #(.DATA_W(DW)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .pix_win  (pix_win),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_pix  (out_pix),
    .busy     (busy),
    .tap_idx  (tap_idx)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  function automatic int unsigned model(input logic [9*DW-1:0] w);
    int unsigned s;
    int unsigned r;
    s = 0;
    for (int k = 0; k < 9; k++) begin
      int unsigned wt;
      wt = (k == 4) ? 4 : ((k % 2) == 1) ? 2 : 1;
      s += wt * int'(w[k*DW +: DW]);
    end
    r = (s + 8) / 16;
    if (r > 255) r = 255;
    return r;
  endfunction

  task automatic scramble();
    for (int k = 0; k < 9; k++) pix_win[k*DW +: DW] = DW'($urandom);
  endtask

  // Called just after a falling edge; returns one falling edge later.
  task automatic send(input logic [9*DW-1:0] w, input int unsigned exp);
    in_valid = 1'b1;
    pix_win  = w;
    check("in_ready_at_offer", in_ready, 1);
    exp_q.push_back(exp);
    @(negedge clk);
    in_valid = 1'b0;
    scramble();
  endtask

  task automatic wait_out(input string tag);
    int lat;
    lat = 1;
    while (!out_valid && lat < 40) begin
      if (lat <= 9) begin
        check("tap_idx_seq", tap_idx, lat - 1);
        check("busy_in_acc", busy, 1);
      end
      scramble();
      @(negedge clk);
      lat++;
    end
    check({tag, "_latency"}, lat, 10);
    check({tag, "_sb_depth"}, exp_q.size(), 1);
    if (exp_q.size() > 0) check({tag, "_out_pix"}, out_pix, exp_q.pop_front());
  endtask

  task automatic run_one(input string tag, input logic [9*DW-1:0] w, input int unsigned exp);
    send(w, exp);
    wait_out(tag);
    @(negedge clk);
    check({tag, "_valid_drop"}, out_valid, 0);
    check({tag, "_idle_ready"}, in_ready, 1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [9*DW-1:0] w;
    logic [9*DW-1:0] wins [4];
    int k;
    int bad;

    // Reset state
    repeat (2) @(negedge clk);
    check("rst_in_ready", in_ready, 1);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_pix", out_pix, 0);
    check("rst_busy", busy, 0);
    check("rst_tap_idx", tap_idx, 0);

    // First edge after release accepts a window; all-zero window
    rst = 1'b0;
    run_one("zero", '0, 0);

    for (int i = 0; i < 9; i++) w[i*DW +: DW] = 8'd255;
    @(negedge clk);
    run_one("all255", w, 255);

    for (int i = 0; i < 9; i++) w[i*DW +: DW] = 8'd100;
    @(negedge clk);
    run_one("all100", w, 100);

    w = '0; w[4*DW +: DW] = 8'd100;
    @(negedge clk);
    run_one("centre100", w, 25);

    w = '0;
    w[0*DW +: DW] = 8'd16; w[2*DW +: DW] = 8'd16;
    w[6*DW +: DW] = 8'd16; w[8*DW +: DW] = 8'd16;
    @(negedge clk);
    run_one("corners16", w, 4);

    w = '0; w[1*DW +: DW] = 8'd1;
    @(negedge clk);
    run_one("tap1_one", w, 0);

    w = '0; w[4*DW +: DW] = 8'd2;
    @(negedge clk);
    run_one("tap4_two", w, 1);

    for (int r = 0; r < 4; r++) begin
      for (int i = 0; i < 9; i++) w[i*DW +: DW] = DW'($urandom);
      @(negedge clk);
      run_one("random", w, model(w));
    end

    // Backpressure in OUT
    out_ready = 1'b0;
    w = '0; w[4*DW +: DW] = 8'd100;
    @(negedge clk);
    send(w, 25);
    wait_out("stall");
    for (int i = 0; i < 5; i++) begin
      in_valid = (i % 2 == 0);
      scramble();
      @(negedge clk);
      check("stall_valid", out_valid, 1);
      check("stall_pix", out_pix, 25);
      check("stall_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    check("stall_release_valid", out_valid, 0);
    check("stall_release_ready", in_ready, 1);
    @(negedge clk);
    check("stall_no_accept", busy, 0);

    // Reset during ACC at tap 4
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = 8'd255;
    send(w, 255);
    k = 0;
    while (tap_idx != 4'd4 && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("reach_tap4", tap_idx, 4);
    rst = 1'b1;
    #1;
    check("acc_rst_in_ready", in_ready, 1);
    check("acc_rst_out_valid", out_valid, 0);
    check("acc_rst_out_pix", out_pix, 0);
    check("acc_rst_busy", busy, 0);
    check("acc_rst_tap_idx", tap_idx, 0);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    w = '0; w[4*DW +: DW] = 8'd100;
    run_one("after_rst", w, 25);

    // Reset during OUT
    out_ready = 1'b0;
    for (int i = 0; i < 9; i++) w[i*DW +: DW] = 8'd100;
    @(negedge clk);
    send(w, 100);
    wait_out("out_rst");
    rst = 1'b1;
    #1;
    check("out_rst_valid", out_valid, 0);
    check("out_rst_pix", out_pix, 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (out_valid !== 1'b0 || busy !== 1'b0) bad++;
    end
    check("out_rst_quiet", bad, 0);
    out_ready = 1'b1;

    // Back-to-back with in_valid held high
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 9; j++) wins[i][j*DW +: DW] = DW'($urandom);
    in_valid = 1'b1;
    pix_win  = wins[0];
    for (int n = 0; n < 3; n++) begin
      check("b2b_accept", in_ready, 1);
      exp_q.push_back(model(wins[n]));
      bad = 0;
      for (int j = 1; j <= 10; j++) begin
        @(negedge clk);
        if (j < 10) begin
          if (out_valid !== 1'b0 || in_ready !== 1'b0) bad++;
          scramble();
        end else begin
          check("b2b_valid", out_valid, 1);
          check("b2b_sb_depth", exp_q.size(), 1);
          if (exp_q.size() > 0) check("b2b_out_pix", out_pix, exp_q.pop_front());
          if (n == 2) in_valid = 1'b0;
          else pix_win = wins[n+1];
        end
      end
      check("b2b_acc_phase", bad, 0);
      @(negedge clk);
    end
    check("b2b_final_idle", busy, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
